// File: rtl/ej32_lsu_if.sv
// ej32_lsu_if: core-side handshake and byte-wide memory bus of the eJ32 load/store sequencer
interface ej32_lsu_if #(parameter int ASZ = 17, parameter int DSZ = 32);
  logic           req;
  logic           we;
  logic [1:0]     sz;
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] wdata;
  logic           busy;
  logic           done;
  logic [DSZ-1:0] rdata;
  logic [ASZ-1:0] m_addr;
  logic           m_we;
  logic [7:0]     m_wdat;
  logic [7:0]     m_rdat;
  modport slave (input req, we, sz, addr, wdata, m_rdat, output busy, done, rdata, m_addr, m_we, m_wdat);
  modport master(output req, we, sz, addr, wdata, m_rdat, input busy, done, rdata, m_addr, m_we, m_wdat);
endinterface

// File: rtl/ej32_lsu.sv
// ej32_lsu: big-endian byte-serial load/store sequencer with req/busy/done handshake
module ej32_lsu #(parameter int ASZ = 17, parameter int DSZ = 32) (
    input logic      clk,
    input logic      rst,
    ej32_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, FILL, DONE} state_t;
    state_t         state, state_n;
    logic [1:0]     i, nm1;
    logic           we_l;
    logic [23:0]    wsh, acc;
    logic [31:0]    al, merged, sext;
    logic [DSZ-1:0] rdata;
    logic [ASZ-1:0] m_addr;
    logic           m_we;
    logic [7:0]     m_wdat;
    logic           last;

    assign last = i == nm1;
    // store value pre-shifted so the first byte of the transfer sits in the top byte
    assign al = bus.sz == 2'd0 ? bus.wdata << 24 : bus.sz == 2'd1 ? bus.wdata << 16 : bus.wdata;
    assign merged = {acc, bus.m_rdat};
    assign sext = nm1 == 2'd0 ? {{24{merged[7]}}, merged[7:0]} :
                  nm1 == 2'd1 ? {{16{merged[15]}}, merged[15:0]} : merged;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = bus.req ? XFER : IDLE;
            XFER:    state_n = last ? (we_l ? DONE : FILL) : XFER;
            FILL:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            nm1    <= '0;
            we_l   <= 1'b0;
            wsh    <= '0;
            acc    <= '0;
            rdata  <= '0;
            m_addr <= '0;
            m_we   <= 1'b0;
            m_wdat <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req) begin
                we_l   <= bus.we;
                nm1    <= bus.sz == 2'd0 ? 2'd0 : bus.sz == 2'd1 ? 2'd1 : 2'd3;
                i      <= '0;
                m_addr <= bus.addr;
                m_we   <= bus.we;
                m_wdat <= al[31:24];
                wsh    <= al[23:0];
            end else if (state == XFER) begin
                if (last) m_we <= 1'b0;
                else begin
                    i      <= i + 2'd1;
                    m_addr <= m_addr + ASZ'(1);
                    m_wdat <= wsh[23:16];
                    wsh    <= {wsh[15:0], 8'h00};
                end
                // read data trails its address by one cycle
                if (!we_l && i != 2'd0) acc <= merged[23:0];
            end else if (state == FILL) begin
                rdata <= sext;
            end
        end
    end

    assign bus.busy   = state == XFER || state == FILL;
    assign bus.done   = state == DONE;
    assign bus.rdata  = rdata;
    assign bus.m_addr = m_addr;
    assign bus.m_we   = m_we;
    assign bus.m_wdat = m_wdat;
endmodule

// File: tb/tb_ej32_lsu.sv
// tb_ej32_lsu: randomized and directed checks of ej32_lsu against a byte-array memory model
module tb_ej32_lsu;
    localparam int ASZ = 17;
    localparam int MSK = (1 << ASZ) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ej32_lsu_if #(.ASZ(ASZ), .DSZ(32)) bus();
    ej32_lsu #(.ASZ(ASZ), .DSZ(32)) dut(.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem  [0:MSK];
    logic [7:0] rmem [0:MSK];
    logic [24:0] wq[$];
    int checks = 0;
    int fails = 0;
    logic [31:0] last_rd = '0;

    // memory: writes on the strobe, read data one cycle after the address
    always @(posedge clk) begin
        if (bus.m_we) mem[bus.m_addr] <= bus.m_wdat;
        bus.m_rdat <= mem[bus.m_addr];
    end

    always @(negedge clk) if (bus.m_we) wq.push_back({bus.m_addr, bus.m_wdat});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] s, input int a);
        int n = nb(s);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(rmem[(a + k) & MSK]);
        if (n == 1) v = int'(byte'(v));
        else if (n == 2) v = int'(shortint'(v));
        return v;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic xfer(input bit w, input logic [1:0] s, input logic [16:0] a, input logic [31:0] d);
        int n = nb(s);
        int cyc;
        logic [31:0] v;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.sz = s; bus.addr = a; bus.wdata = d;
        wq.delete();
        @(negedge clk);
        bus.req = 1'b0;
        chk("busy_c1", 32'(bus.busy), 1);
        wait_done(cyc);
        chk(w ? "st_latency" : "ld_latency", cyc, w ? n + 1 : n + 2);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("mwe_at_done", 32'(bus.m_we), 0);
        if (w) begin
            chk("wr_count", wq.size(), n);
            for (int k = 0; k < n; k++) begin
                logic [7:0] b = 8'(d >> (8 * (n - 1 - k)));
                int ad = (int'(a) + k) & MSK;
                rmem[ad] = b;
                if (k < wq.size()) begin
                    chk("wr_addr", 32'(wq[k][24:8]), ad);
                    chk("wr_byte", 32'(wq[k][7:0]), 32'(b));
                end
            end
            chk("st_rdata_kept", bus.rdata, last_rd);
        end else begin
            chk("ld_no_write", wq.size(), 0);
            v = ref_load(s, int'(a));
            chk("ld_rdata", bus.rdata, v);
            last_rd = v;
        end
    endtask

    initial begin
        int cyc;
        for (int k = 0; k <= MSK; k++) begin
            mem[k] = 8'($urandom);
            rmem[k] = mem[k];
        end
        bus.req = 1'b0; bus.we = 1'b0; bus.sz = 2'd0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mwe", 32'(bus.m_we), 0);
        chk("rst_maddr", 32'(bus.m_addr), 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b0;

        xfer(1, 2'd2, 17'h100, 32'h12345678);
        xfer(0, 2'd2, 17'h100, 0);
        chk("dir_word", bus.rdata, 32'h12345678);
        xfer(1, 2'd0, 17'h200, 32'h80);
        xfer(0, 2'd0, 17'h200, 0);
        chk("dir_sx_byte", bus.rdata, 32'hFFFFFF80);
        xfer(1, 2'd1, 17'h210, 32'h7FFF);
        xfer(0, 2'd1, 17'h210, 0);
        chk("dir_sx_short_pos", bus.rdata, 32'h00007FFF);
        xfer(1, 2'd1, 17'h220, 32'h8001);
        xfer(0, 2'd1, 17'h220, 0);
        chk("dir_sx_short_neg", bus.rdata, 32'hFFFF8001);
        xfer(1, 2'd3, 17'h1FFFE, 32'hCAFEBABE);
        chk("wrap_lo0", 32'(mem[0]), 32'hBA);
        chk("wrap_lo1", 32'(mem[1]), 32'hBE);
        xfer(0, 2'd3, 17'h1FFFE, 0);
        chk("dir_wrap_load", bus.rdata, 32'hCAFEBABE);

        // req held through a whole store and its DONE cycle
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.sz = 2'd2; bus.addr = 17'h300; bus.wdata = 32'hDEADBEEF;
        wq.delete();
        repeat (5) @(negedge clk);
        chk("hs_done_c5", 32'(bus.done), 1);
        @(negedge clk);
        chk("hs_idle_c6", 32'(bus.busy), 0);
        chk("hs_writes_one", wq.size(), 4);
        @(negedge clk);
        bus.req = 1'b0;
        chk("hs_accept_c7", 32'(bus.busy), 1);
        wait_done(cyc);
        chk("hs_latency", cyc, 5);
        chk("hs_writes_two", wq.size(), 8);
        for (int k = 0; k < 4; k++) rmem[16'h300 + k] = 8'(32'hDEADBEEF >> (8 * (3 - k)));
        xfer(0, 2'd2, 17'h300, 0);

        // reset just after the edge that commits the second byte
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.sz = 2'd2; bus.addr = 17'h100; bus.wdata = 32'hAABBCCDD;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_mwe", 32'(bus.m_we), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_maddr", 32'(bus.m_addr), 0);
        chk("mrst_rdata", bus.rdata, 0);
        rmem[16'h100] = 8'hAA;
        rmem[16'h101] = 8'hBB;
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 2'd2, 17'h100, 0);
        chk("mrst_partial", bus.rdata, 32'hAABB5678);

        repeat (60) begin
            logic [16:0] a = ($urandom_range(0, 1) != 0 ? 17'h1FFF0 : 17'h00400) + 17'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
